// File: rtl/regfile_pkg.sv
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared helpers and types for the multi-port physical register
//             file (address-width helper, default entry/address types and
//             the ready value every entry takes on reset).
//  Ports    : none (package)
//  Config   : REGFILE_BYPASS_EN selects same-cycle write-to-read forwarding
//             in regfile_rd_port / regfile_mp.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  // Address width for a given depth; never below one bit.
  function automatic int regfile_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_DEPTH = 32;

  typedef logic [DEFAULT_WIDTH-1:0]              regfile_data_t;
  typedef logic [regfile_aw(DEFAULT_DEPTH)-1:0]  regfile_addr_t;

  // Every entry holds a committed value after reset, so all start ready.
  localparam logic RESET_READY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/regfile_rd_port.sv
// ============================================================================
//  Module   : regfile_rd_port
//  Purpose  : One read port of the register file: combinational entry/ready
//             mux, zero-register override and (optionally) same-cycle
//             forwarding from the write ports.
//  Ports    : rd_addr            read address
//             mem / ready        current storage contents and ready bits
//             rd_data / rd_ready read result (combinational)
//             reset, wr_*, alloc_*  forwarding inputs (REGFILE_BYPASS_EN only)
//  Config   : REGFILE_BYPASS_EN defined -> forwarding enabled.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
`ifdef REGFILE_BYPASS_EN
  parameter int NUM_WR   = 2,
`endif
  parameter int ZERO_REG = 31,
  localparam int AW      = regfile_aw(DEPTH)
) (
  input  logic [AW-1:0]                 rd_addr,
  input  logic [WIDTH-1:0]              mem [DEPTH],
  input  logic [DEPTH-1:0]              ready,
`ifdef REGFILE_BYPASS_EN
  input  logic                          reset,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_addr,
  input  logic [NUM_WR-1:0][WIDTH-1:0]  wr_data,
  input  logic                          alloc_en,
  input  logic [AW-1:0]                 alloc_addr,
`endif
  output logic [WIDTH-1:0]              rd_data,
  output logic                          rd_ready
);

  localparam bit            c_HAS_ZERO  = (ZERO_REG < DEPTH);
  localparam logic [AW-1:0] c_ZERO_ADDR = c_HAS_ZERO ? AW'(ZERO_REG) : '0;

  logic w_is_zero;
`ifdef REGFILE_BYPASS_EN
  logic w_hit;
`endif

  assign w_is_zero = c_HAS_ZERO && (rd_addr == c_ZERO_ADDR);

  always_comb begin
    rd_data  = mem[rd_addr];
    rd_ready = ready[rd_addr];
`ifdef REGFILE_BYPASS_EN
    w_hit = 1'b0;
    // Storage is already cleared asynchronously during reset; forwarding
    // must not leak the in-flight write past it.
    if (!reset && !w_is_zero) begin
      // Ascending scan: the highest-index matching port wins, as in storage.
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr[k] == rd_addr)) begin
          w_hit    = 1'b1;
          rd_data  = wr_data[k];
          rd_ready = 1'b1;
        end
      end
      // A same-edge alloc is the newer producer: value forwarded, not ready.
      if (w_hit && alloc_en && (alloc_addr == rd_addr)) begin
        rd_ready = 1'b0;
      end
    end
`endif
    if (w_is_zero) begin
      rd_data  = '0;
      rd_ready = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Parametrised multi-port physical register file with a per-entry
//             ready (scoreboard) bit. Rename allocates (ready cleared),
//             writeback writes (ready set), issue reads data plus ready.
//  Ports    : clk, reset (async, active-high)
//             rd_addr[NUM_RD]  -> rd_data[NUM_RD], rd_ready[NUM_RD]
//             wr_en/wr_addr/wr_data[NUM_WR]  writeback ports
//             alloc_en, alloc_addr           rename allocation
//  Config   : REGFILE_BYPASS_EN defined -> same-cycle write-to-read
//             forwarding; undefined -> writes visible the following cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 31,
  localparam int AW      = regfile_aw(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_RD-1:0][AW-1:0]     rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]             rd_ready,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_addr,
  input  logic [NUM_WR-1:0][WIDTH-1:0]  wr_data,
  input  logic                          alloc_en,
  input  logic [AW-1:0]                 alloc_addr
);

  localparam bit c_HAS_ZERO = (ZERO_REG < DEPTH);

  logic [WIDTH-1:0] r_mem   [DEPTH];
  logic [DEPTH-1:0] r_ready;

  logic [DEPTH-1:0] w_we;
  logic [DEPTH-1:0] w_alloc;
  logic [WIDTH-1:0] w_wdata [DEPTH];

  // Per-entry write enable / data select. Ports are scanned in ascending
  // order so the highest-index port wins a collision. The zero register
  // never accepts a write or an allocation.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_we[e]    = 1'b0;
      w_wdata[e] = r_mem[e];
      w_alloc[e] = alloc_en && (alloc_addr == AW'(e));
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr[k] == AW'(e))) begin
          w_we[e]    = 1'b1;
          w_wdata[e] = wr_data[k];
        end
      end
      if (c_HAS_ZERO && (e == ZERO_REG)) begin
        w_we[e]    = 1'b0;
        w_alloc[e] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_mem[e] <= '0;
      end
      r_ready <= {DEPTH{RESET_READY}};
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_we[e]) begin
          r_mem[e] <= w_wdata[e];
        end
        // Alloc beats a same-edge write: the allocating op is the newer producer.
        if (w_alloc[e]) begin
          r_ready[e] <= 1'b0;
        end else if (w_we[e]) begin
          r_ready[e] <= 1'b1;
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    regfile_rd_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
`ifdef REGFILE_BYPASS_EN
      .NUM_WR   (NUM_WR),
`endif
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .rd_addr    (rd_addr[r]),
      .mem        (r_mem),
      .ready      (r_ready),
`ifdef REGFILE_BYPASS_EN
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
`endif
      .rd_data    (rd_data[r]),
      .rd_ready   (rd_ready[r])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Self-checking bench for regfile_mp (default 64x32, 2R/2W).
//             Stimulus pushes expected read results into a queue; a monitor
//             on the falling edge pops and compares them against the DUT.
//  Config   : REGFILE_BYPASS_EN changes same-cycle read expectations.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;
  import regfile_pkg::*;

  localparam logic [63:0] K = 64'h0000010204080001;

  logic                 clk;
  logic                 reset;
  logic [1:0][4:0]      rd_addr;
  logic [1:0][63:0]     rd_data;
  logic [1:0]           rd_ready;
  logic [1:0]           wr_en;
  logic [1:0][4:0]      wr_addr;
  logic [1:0][63:0]     wr_data;
  logic                 alloc_en;
  logic [4:0]           alloc_addr;

  regfile_mp #(
    .WIDTH(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(31)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            nm;
    logic [1:0][63:0] d;
    logic [1:0]       r;
  } exp_t;

  exp_t q[$];
  logic chk_vld;
  int   checks = 0;
  int   errors = 0;

  function automatic regfile_data_t pat(input int i);
    return 64'(i) * K;
  endfunction

  // Monitor: compare both read ports whenever stimulus flags a check.
  always @(negedge clk) begin
    if (chk_vld) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got nothing queued, required one entry");
      end else begin
        exp_t e;
        e = q.pop_front();
        for (int p = 0; p < 2; p++) begin
          checks++;
          if (rd_data[p] !== e.d[p] || rd_ready[p] !== e.r[p]) begin
            errors++;
            $display("FAIL %s port%0d: got data=%h ready=%b, required data=%h ready=%b",
                     e.nm, p, rd_data[p], rd_ready[p], e.d[p], e.r[p]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic next();
    @(posedge clk);
    #1;
    wr_en    = '0;
    alloc_en = 1'b0;
    chk_vld  = 1'b0;
  endtask

  task automatic wr(input int k, input int a, input logic [63:0] d);
    wr_en[k]   = 1'b1;
    wr_addr[k] = 5'(a);
    wr_data[k] = d;
  endtask

  task automatic alloc(input int a);
    alloc_en   = 1'b1;
    alloc_addr = 5'(a);
  endtask

  task automatic chk(input string nm,
                     input int a0, input logic [63:0] d0, input logic r0,
                     input int a1, input logic [63:0] d1, input logic r1);
    exp_t e;
    rd_addr[0] = 5'(a0);
    rd_addr[1] = 5'(a1);
    e.nm = nm;
    e.d[0] = d0; e.r[0] = r0;
    e.d[1] = d1; e.r[1] = r1;
    q.push_back(e);
    chk_vld = 1'b1;
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; chk_vld = 1'b0;

    // Reset state
    next();
    chk("reset_state", 0, 64'h0, 1'b1, 31, 64'h0, 1'b1);
    next();
    reset = 1'b0;

    // Pattern fill, alternating write ports
    for (int i = 0; i < 31; i++) begin
      wr(i % 2, i, pat(i));
      next();
    end
    for (int i = 0; i < 32; i++) begin
      chk("pattern", i, (i == 31) ? 64'h0 : pat(i), 1'b1,
                     31 - i, (i == 0) ? 64'h0 : pat(31 - i), 1'b1);
      next();
    end

    // Zero register ignores write and alloc
    wr(0, 31, 64'hA0);
    alloc(31);
    next();
    chk("zero_reg", 31, 64'h0, 1'b1, 31, 64'h0, 1'b1);
    next();

    // Write-write collision: highest port wins
    wr(0, 5, 64'h11);
    wr(1, 5, 64'h22);
    next();
    chk("collision", 5, 64'h22, 1'b1, 4, pat(4), 1'b1);
    next();

    // Scoreboard: alloc, alloc+write, write
    alloc(7);
    next();
    chk("alloc", 7, pat(7), 1'b0, 6, pat(6), 1'b1);
    next();
    alloc(7);
    wr(0, 7, 64'h55);
    next();
    chk("alloc_write", 7, 64'h55, 1'b0, 7, 64'h55, 1'b0);
    next();
    wr(1, 7, 64'h66);
    next();
    chk("write_ready", 7, 64'h66, 1'b1, 8, pat(8), 1'b1);
    next();

    // Same-cycle read of an entry being written
    wr(0, 9, 64'hBEEF);
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle", 9, 64'hBEEF, 1'b1, 9, 64'hBEEF, 1'b1);
`else
    chk("same_cycle", 9, pat(9), 1'b1, 9, pat(9), 1'b1);
`endif
    next();
    chk("next_cycle", 9, 64'hBEEF, 1'b1, 10, pat(10), 1'b1);
    next();

    // Same-cycle write+alloc, and same-cycle colliding writes
    wr(0, 10, 64'hCAFE);
    alloc(10);
    wr(1, 11, 64'hB1);
`ifdef REGFILE_BYPASS_EN
    chk("byp_alloc", 10, 64'hCAFE, 1'b0, 11, 64'hB1, 1'b1);
`else
    chk("byp_alloc", 10, pat(10), 1'b1, 11, pat(11), 1'b1);
`endif
    next();
    wr(0, 11, 64'hA1);
    wr(1, 11, 64'hB2);
    wr(0, 11, 64'hA1);
`ifdef REGFILE_BYPASS_EN
    chk("byp_collide", 10, 64'hCAFE, 1'b0, 11, 64'hB2, 1'b1);
`else
    chk("byp_collide", 10, 64'hCAFE, 1'b0, 11, 64'hB1, 1'b1);
`endif
    next();
    wr(0, 31, 64'h77);
    chk("byp_zero", 31, 64'h0, 1'b1, 11, 64'hB2, 1'b1);
    next();

    // Asynchronous reset mid-run with a write pending
    alloc(12);
    next();
    wr(0, 3, 64'h123);
    reset = 1'b1;
    chk("rst_async", 3, 64'h0, 1'b1, 9, 64'h0, 1'b1);
    next();
    chk("rst_hold", 3, 64'h0, 1'b1, 12, 64'h0, 1'b1);
    next();
    reset = 1'b0;
    chk("rst_after", 3, 64'h0, 1'b1, 12, 64'h0, 1'b1);
    next();
    next();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
